// File: rtl/motor_pkg.sv
// Shared encodings for the motor PWM drive: drive states, DIR steering codes,
// H-bridge input codes, and the DIR decode helper.
package motor_pkg;

  localparam logic [1:0] ST_STOP   = 2'b00;
  localparam logic [1:0] ST_FWD    = 2'b01;
  localparam logic [1:0] ST_VEER_L = 2'b10;
  localparam logic [1:0] ST_VEER_R = 2'b11;

  localparam logic [3:0] DIR_FWD    = 4'b0000;
  localparam logic [3:0] DIR_VEER_L = 4'b0101;
  localparam logic [3:0] DIR_VEER_R = 4'b1001;
  localparam logic [3:0] DIR_STOP   = 4'b1111;

  localparam logic [1:0] HB_FWD   = 2'b10;
  localparam logic [1:0] HB_BRAKE = 2'b11;

  typedef struct packed {
    logic [1:0] state;
    logic [7:0] tgt_l;
    logic [7:0] tgt_r;
  } decode_t;

  // Anything other than the three run codes brakes, including DIR_STOP itself.
  function automatic decode_t decode_dir(input logic [3:0] dir,
                                         input logic [7:0] full,
                                         input logic [7:0] veer);
    decode_t d;
    d = '{state: ST_STOP, tgt_l: 8'd0, tgt_r: 8'd0};
    case (dir)
      DIR_FWD:    d = '{state: ST_FWD,    tgt_l: full, tgt_r: full};
      DIR_VEER_L: d = '{state: ST_VEER_L, tgt_l: veer, tgt_r: full};
      DIR_VEER_R: d = '{state: ST_VEER_R, tgt_l: full, tgt_r: veer};
      default:    d = '{state: ST_STOP,   tgt_l: 8'd0, tgt_r: 8'd0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/duty_ramp.sv
// One channel's duty register: saturating step toward target at each PWM wrap,
// forced to zero on stop. MOTOR_RAMP_EN selects stepped ramp; otherwise direct load.
module duty_ramp
  import motor_pkg::*;
#(
  parameter int RAMP_STEP = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wrap,
  input  logic       stop,
  input  logic [7:0] target,
  output logic [7:0] duty,
  output logic       at_target
);

`ifdef MOTOR_RAMP_EN
  localparam logic [9:0] STEP = 10'(RAMP_STEP);
`else
  // Any step of 256 or more saturates in one wrap, so direct load is a very wide step.
  localparam logic [9:0] STEP = 10'(RAMP_STEP + 256);
`endif

  logic [9:0] tgt_w;
  logic [9:0] up_sum;
  logic [9:0] dn_diff;
  logic [7:0] duty_next;

  always_comb begin
    tgt_w     = {2'b00, target};
    up_sum    = {2'b00, duty} + STEP;
    dn_diff   = {2'b00, duty} - STEP;
    duty_next = duty;
    if (duty < target) begin
      duty_next = (up_sum > tgt_w) ? target : up_sum[7:0];
    end else if (duty > target) begin
      // dn_diff[9] set means the subtraction went below zero.
      duty_next = (dn_diff[9] || (dn_diff < tgt_w)) ? target : dn_diff[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= 8'd0;
    end else if (stop) begin
      duty <= 8'd0;
    end else if (wrap) begin
      duty <= duty_next;
    end
  end

  assign at_target = (duty == target);

endmodule

// File: rtl/motor_pwm_drive.sv
// Left/right H-bridge PWM drive from the registered DIR steering code, with soft
// duty changes at PWM wraps and immediate braking. Optional macro: MOTOR_RAMP_EN.
module motor_pwm_drive
  import motor_pkg::*;
#(
  parameter int PRESCALE  = 4,
  parameter int FULL_DUTY = 255,
  parameter int VEER_DUTY = 96,
  parameter int RAMP_STEP = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] DIR,
  output logic       L_PWM,
  output logic       R_PWM,
  output logic [1:0] L_IN,
  output logic [1:0] R_IN,
  output logic [1:0] STATE,
  output logic       AT_SPEED
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [3:0]    dir_q;
  logic [PW-1:0] ps_cnt;
  logic [7:0]    pwm_cnt;
  logic          tick;
  logic          wrap;
  logic [1:0]    state_q;
  decode_t       dec;
  logic          stop_now;
  logic [7:0]    duty_l;
  logic [7:0]    duty_r;
  logic          at_l;
  logic          at_r;
  logic          l_pwm_q;
  logic          r_pwm_q;
  logic          at_speed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= DIR_STOP;
    end else begin
      dir_q <= DIR;
    end
  end

  assign tick = (ps_cnt == PS_LAST);
  assign wrap = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt  <= '0;
      pwm_cnt <= 8'd0;
    end else begin
      ps_cnt <= tick ? '0 : ps_cnt + PW'(1);
      if (tick) begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
    end
  end

  assign dec      = decode_dir(dir_q, 8'(FULL_DUTY), 8'(VEER_DUTY));
  assign stop_now = (dec.state == ST_STOP) && (state_q != ST_STOP);

  // STOP acts at once; run states only change at a period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STOP;
    end else if (stop_now) begin
      state_q <= ST_STOP;
    end else if (wrap) begin
      state_q <= dec.state;
    end
  end

  duty_ramp #(.RAMP_STEP(RAMP_STEP)) u_ramp_l (
    .clk       (clk),
    .rst_n     (rst_n),
    .wrap      (wrap),
    .stop      (stop_now),
    .target    (dec.tgt_l),
    .duty      (duty_l),
    .at_target (at_l)
  );

  duty_ramp #(.RAMP_STEP(RAMP_STEP)) u_ramp_r (
    .clk       (clk),
    .rst_n     (rst_n),
    .wrap      (wrap),
    .stop      (stop_now),
    .target    (dec.tgt_r),
    .duty      (duty_r),
    .at_target (at_r)
  );

  // The PWM registers are forced low on the same edge that zeroes the duties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_pwm_q    <= 1'b0;
      r_pwm_q    <= 1'b0;
      at_speed_q <= 1'b0;
    end else begin
      l_pwm_q    <= stop_now ? 1'b0 : (pwm_cnt < duty_l);
      r_pwm_q    <= stop_now ? 1'b0 : (pwm_cnt < duty_r);
      at_speed_q <= at_l && at_r && (state_q != ST_STOP);
    end
  end

  assign L_PWM    = l_pwm_q;
  assign R_PWM    = r_pwm_q;
  assign STATE    = state_q;
  assign AT_SPEED = at_speed_q;
  assign L_IN     = (state_q == ST_STOP) ? HB_BRAKE : HB_FWD;
  assign R_IN     = (state_q == ST_STOP) ? HB_BRAKE : HB_FWD;

endmodule

// File: tb/tb_motor_pwm_drive.sv
// Directed bench for motor_pwm_drive: duty is observed as PWM high cycles per
// period, using a bench-side cycle counter to locate period boundaries.
`timescale 1ns/1ps
module tb_motor_pwm_drive;

  localparam int PRESCALE   = 4;
  localparam int PERIOD_CLK = PRESCALE * 256;
`ifdef MOTOR_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] dir = 4'b1111;
  logic       L_PWM, R_PWM, AT_SPEED;
  logic [1:0] L_IN, R_IN, STATE;

  int checks = 0;
  int failures = 0;
  int cyc;
  logic [7:0] exp_q[$];

  motor_pwm_drive #(.PRESCALE(PRESCALE), .FULL_DUTY(255), .VEER_DUTY(96), .RAMP_STEP(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .DIR      (dir),
    .L_PWM    (L_PWM),
    .R_PWM    (R_PWM),
    .L_IN     (L_IN),
    .R_IN     (R_IN),
    .STATE    (STATE),
    .AT_SPEED (AT_SPEED)
  );

  // ---------------- clock / reset / timebase model ----------------
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [7:0] step_duty(input logic [7:0] cur, input logic [7:0] tgt);
    int n;
    if (!RAMP) return tgt;
    if (cur < tgt) begin
      n = int'(cur) + 16;
      if (n > int'(tgt)) n = int'(tgt);
    end else begin
      n = int'(cur) - 16;
      if (n < int'(tgt)) n = int'(tgt);
    end
    return 8'(n);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_wrap();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((cyc % PERIOD_CLK != 0) && (guard < 2 * PERIOD_CLK));
    if (guard >= 2 * PERIOD_CLK) begin
      checks++; failures++;
      $display("FAIL wait_wrap: no period boundary within %0d cycles", guard);
    end
  endtask

  task automatic wait_cyc(input int target);
    int guard = 0;
    while ((cyc != target) && (guard < 4 * PERIOD_CLK)) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != target) begin
      checks++; failures++;
      $display("FAIL wait_cyc: cyc=%0d never reached %0d", cyc, target);
    end
  endtask

  // Call at the negedge after a wrap edge; counts high samples over one period.
  task automatic measure(output int hl, output int hr, output logic a1);
    hl = 0; hr = 0; a1 = 1'b0;
    for (int i = 0; i < PERIOD_CLK; i++) begin
      @(negedge clk);
      if (L_PWM === 1'b1) hl++;
      if (R_PWM === 1'b1) hr++;
      if (i == 0) a1 = AT_SPEED;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    dir = 4'b0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({STATE, L_PWM, R_PWM, L_IN, R_IN, AT_SPEED} !== {2'b00, 1'b0, 1'b0, 2'b11, 2'b11, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: STATE=%b L_PWM=%b R_PWM=%b L_IN=%b R_IN=%b AT_SPEED=%b want 00 0 0 11 11 0",
               STATE, L_PWM, R_PWM, L_IN, R_IN, AT_SPEED);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fwd_ramp();
    logic [7:0] cur;
    logic [7:0] e;
    int hl, hr;
    logic a1;
    wait_cyc(PERIOD_CLK - 1);
    checks++;
    if (STATE !== 2'b00) begin
      failures++;
      $display("FAIL fwd_before_wrap: STATE=%b want 00", STATE);
    end
    wait_cyc(PERIOD_CLK);
    checks++;
    if ({STATE, L_IN, R_IN} !== {2'b01, 2'b10, 2'b10}) begin
      failures++;
      $display("FAIL fwd_first_wrap: STATE=%b L_IN=%b R_IN=%b want 01 10 10", STATE, L_IN, R_IN);
    end
    cur = 8'd0;
    do begin
      cur = step_duty(cur, 8'd255);
      exp_q.push_back(cur);
    end while (cur != 8'd255);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      measure(hl, hr, a1);
      checks++;
      if (hl != int'(e) * PRESCALE || hr != int'(e) * PRESCALE || a1 !== (e == 8'd255)) begin
        failures++;
        $display("FAIL fwd_ramp: high_l=%0d high_r=%0d at_speed=%b want %0d %0d %b",
                 hl, hr, a1, int'(e) * PRESCALE, int'(e) * PRESCALE, (e == 8'd255));
      end
    end
  endtask

  task automatic test_veer_l();
    logic [7:0] cur;
    logic [7:0] e;
    int hl, hr;
    logic a1;
    dir = 4'b0101;
    measure(hl, hr, a1);
    checks++;
    if (hl != 255 * PRESCALE || hr != 255 * PRESCALE) begin
      failures++;
      $display("FAIL veer_l_hold: high_l=%0d high_r=%0d want %0d %0d", hl, hr, 255 * PRESCALE, 255 * PRESCALE);
    end
    checks++;
    if ({STATE, L_IN, R_IN} !== {2'b10, 2'b10, 2'b10}) begin
      failures++;
      $display("FAIL veer_l_state: STATE=%b L_IN=%b R_IN=%b want 10 10 10", STATE, L_IN, R_IN);
    end
    cur = 8'd255;
    do begin
      cur = step_duty(cur, 8'd96);
      exp_q.push_back(cur);
    end while (cur != 8'd96);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      measure(hl, hr, a1);
      checks++;
      if (hl != int'(e) * PRESCALE || hr != 255 * PRESCALE || a1 !== (e == 8'd96)) begin
        failures++;
        $display("FAIL veer_l_ramp: high_l=%0d high_r=%0d at_speed=%b want %0d %0d %b",
                 hl, hr, a1, int'(e) * PRESCALE, 255 * PRESCALE, (e == 8'd96));
      end
    end
  endtask

  task automatic test_stop_mid_ramp();
    int hl, hr;
    logic a1;
    dir = 4'b0000;
    wait_wrap();
    wait_wrap();
    repeat (20) @(negedge clk);
    checks++;
    if ({L_PWM, R_PWM} !== 2'b11) begin
      failures++;
      $display("FAIL stop_pre_pwm: L_PWM=%b R_PWM=%b want 1 1", L_PWM, R_PWM);
    end
    dir = 4'b1111;
    @(negedge clk);
    checks++;
    if (STATE !== 2'b01) begin
      failures++;
      $display("FAIL stop_latency: STATE=%b want 01 one clk after DIR change", STATE);
    end
    @(negedge clk);
    checks++;
    if ({STATE, L_PWM, R_PWM, L_IN, R_IN} !== {2'b00, 1'b0, 1'b0, 2'b11, 2'b11}) begin
      failures++;
      $display("FAIL stop_immediate: STATE=%b L_PWM=%b R_PWM=%b L_IN=%b R_IN=%b want 00 0 0 11 11",
               STATE, L_PWM, R_PWM, L_IN, R_IN);
    end
    wait_wrap();
    measure(hl, hr, a1);
    checks++;
    if (hl != 0 || hr != 0 || a1 !== 1'b0 || STATE !== 2'b00) begin
      failures++;
      $display("FAIL stop_hold: high_l=%0d high_r=%0d at_speed=%b STATE=%b want 0 0 0 00", hl, hr, a1, STATE);
    end
  endtask

  task automatic test_illegal_code();
    int hl, hr;
    logic a1;
    logic [7:0] e;
    dir = 4'b0000;
    wait_wrap();
    repeat (20) @(negedge clk);
    checks++;
    if ({STATE, L_PWM} !== {2'b01, 1'b1}) begin
      failures++;
      $display("FAIL illegal_pre: STATE=%b L_PWM=%b want 01 1", STATE, L_PWM);
    end
    dir = 4'b0110;
    repeat (2) @(negedge clk);
    checks++;
    if ({STATE, L_PWM, R_PWM, L_IN, R_IN} !== {2'b00, 1'b0, 1'b0, 2'b11, 2'b11}) begin
      failures++;
      $display("FAIL illegal_stop: STATE=%b L_PWM=%b R_PWM=%b L_IN=%b R_IN=%b want 00 0 0 11 11",
               STATE, L_PWM, R_PWM, L_IN, R_IN);
    end
    dir = 4'b0000;
    wait_wrap();
    e = step_duty(8'd0, 8'd255);
    measure(hl, hr, a1);
    checks++;
    if (hl != int'(e) * PRESCALE || hr != int'(e) * PRESCALE) begin
      failures++;
      $display("FAIL illegal_restart: high_l=%0d high_r=%0d want %0d %0d", hl, hr, int'(e) * PRESCALE, int'(e) * PRESCALE);
    end
  endtask

  task automatic test_async_reset();
    int hl, hr;
    logic a1;
    logic [7:0] el, er;
    dir = 4'b1001;
    wait_wrap();
    wait_wrap();
    repeat (20) @(negedge clk);
    checks++;
    if ({STATE, L_PWM, R_PWM} !== {2'b11, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL areset_pre: STATE=%b L_PWM=%b R_PWM=%b want 11 1 1", STATE, L_PWM, R_PWM);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({STATE, L_PWM, R_PWM, L_IN, R_IN, AT_SPEED} !== {2'b00, 1'b0, 1'b0, 2'b11, 2'b11, 1'b0}) begin
      failures++;
      $display("FAIL areset_async: STATE=%b L_PWM=%b R_PWM=%b L_IN=%b R_IN=%b AT_SPEED=%b want 00 0 0 11 11 0",
               STATE, L_PWM, R_PWM, L_IN, R_IN, AT_SPEED);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(PERIOD_CLK - 1);
    checks++;
    if (STATE !== 2'b00) begin
      failures++;
      $display("FAIL areset_before_wrap: STATE=%b want 00", STATE);
    end
    wait_cyc(PERIOD_CLK);
    checks++;
    if ({STATE, L_IN, R_IN} !== {2'b11, 2'b10, 2'b10}) begin
      failures++;
      $display("FAIL areset_restart: STATE=%b L_IN=%b R_IN=%b want 11 10 10", STATE, L_IN, R_IN);
    end
    el = step_duty(8'd0, 8'd255);
    er = step_duty(8'd0, 8'd96);
    measure(hl, hr, a1);
    checks++;
    if (hl != int'(el) * PRESCALE || hr != int'(er) * PRESCALE || a1 !== (el == 8'd255 && er == 8'd96)) begin
      failures++;
      $display("FAIL areset_first_period: high_l=%0d high_r=%0d at_speed=%b want %0d %0d %b",
               hl, hr, a1, int'(el) * PRESCALE, int'(er) * PRESCALE, (el == 8'd255 && er == 8'd96));
    end
  endtask

  task automatic test_back_to_back();
    int hl, hr;
    logic a1;
    logic [7:0] el, er;
    dir = 4'b1111;
    repeat (2) @(negedge clk);
    dir = 4'b1001;
    wait_wrap();
    checks++;
    if (STATE !== 2'b11) begin
      failures++;
      $display("FAIL b2b_state: STATE=%b want 11", STATE);
    end
    el = step_duty(8'd0, 8'd255);
    er = step_duty(8'd0, 8'd96);
    measure(hl, hr, a1);
    checks++;
    if (hl != int'(el) * PRESCALE || hr != int'(er) * PRESCALE || a1 !== (el == 8'd255 && er == 8'd96)) begin
      failures++;
      $display("FAIL b2b_veer_r: high_l=%0d high_r=%0d at_speed=%b want %0d %0d %b",
               hl, hr, a1, int'(el) * PRESCALE, int'(er) * PRESCALE, (el == 8'd255 && er == 8'd96));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fwd_ramp();
    test_veer_l();
    test_stop_mid_ramp();
    test_illegal_code();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
